// File: rtl/ampel_ctrl_pkg.sv
// ampel_ctrl_pkg: state encoding and default phase durations for the pedestrian-crossing sequencer
package ampel_ctrl_pkg;
  typedef enum logic [2:0] {
    S_GREEN, S_YELLOW, S_RED_CLR, S_WALK, S_PED_CLR, S_RED_YEL, S_BLINK
  } state_t;
  localparam int T_GREEN_D  = 8;
  localparam int T_YELLOW_D = 3;
  localparam int T_CLEAR_D  = 2;
  localparam int T_WALK_D   = 6;
  localparam int T_REDYEL_D = 1;
  function automatic logic dur_ok(input int d);
    return d >= 1 && d <= 15;
  endfunction
endpackage

// File: rtl/ampel_ctrl_timer.sv
// ampel_ctrl_timer: 4-bit loadable down-counter that stops at 1 (i_load/i_value load, i_tick decrements; o_cnt value, o_last when o_cnt==1)
module ampel_ctrl_timer (
  input  logic       i_clk,
  input  logic       i_load,
  input  logic [3:0] i_value,
  input  logic       i_tick,
  output logic [3:0] o_cnt,
  output logic       o_last
);
  logic [3:0] r_cnt;
  always_ff @(posedge i_clk)
    r_cnt <= i_load ? i_value : (i_tick && r_cnt > 4'd1) ? r_cnt - 4'd1 : r_cnt;
  assign o_cnt  = r_cnt;
  assign o_last = r_cnt == 4'd1;
endmodule

// File: rtl/ampel_ctrl.sv
// ampel_ctrl: pedestrian-crossing light sequencer with request latch, night blink mode and walk countdown
// Ports: i_clk/i_res (sync active-high), i_tick seconds pulse, i_req button level, i_night mode level;
// o_car_r/y/g and o_ped_r/g lamps, o_wait request latch, o_cnt phase timer, o_disp_en display enable (WALK only).
module ampel_ctrl
  import ampel_ctrl_pkg::*;
#(
  parameter int T_GREEN  = T_GREEN_D,
  parameter int T_YELLOW = T_YELLOW_D,
  parameter int T_CLEAR  = T_CLEAR_D,
  parameter int T_WALK   = T_WALK_D,
  parameter int T_REDYEL = T_REDYEL_D
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_tick,
  input  logic       i_req,
  input  logic       i_night,
  output logic       o_car_r,
  output logic       o_car_y,
  output logic       o_car_g,
  output logic       o_ped_r,
  output logic       o_ped_g,
  output logic       o_wait,
  output logic [3:0] o_cnt,
  output logic       o_disp_en
);
  if (!dur_ok(T_GREEN) || !dur_ok(T_YELLOW) || !dur_ok(T_CLEAR) || !dur_ok(T_WALK) || !dur_ok(T_REDYEL)) begin : g_cfg_err
    $error("ampel_ctrl: all phase durations must be in 1..15");
  end
  state_t     r_state, w_next;
  logic       r_wait, r_blink, r_req_q;
  logic       w_last, w_exit, w_enter, w_load, w_clr, w_set;
  logic [3:0] w_value;
  assign w_exit  = i_tick && w_last;
  assign w_enter = w_next != r_state;
  assign w_load  = i_res || w_enter;
  assign w_value = (i_res || w_next == S_GREEN)              ? 4'(T_GREEN)  :
                   w_next == S_YELLOW                        ? 4'(T_YELLOW) :
                   (w_next == S_RED_CLR || w_next == S_PED_CLR) ? 4'(T_CLEAR) :
                   w_next == S_WALK                          ? 4'(T_WALK)   :
                   w_next == S_RED_YEL                       ? 4'(T_REDYEL) : 4'd0;
  // entering WALK or BLINK consumes the request; this beats a simultaneous button edge
  assign w_clr = w_enter && (w_next == S_WALK || w_next == S_BLINK);
  assign w_set = i_req && !r_req_q && r_state != S_WALK && r_state != S_BLINK;
  ampel_ctrl_timer u_timer (
    .i_clk  (i_clk),
    .i_load (w_load),
    .i_value(w_value),
    .i_tick (i_tick),
    .o_cnt  (o_cnt),
    .o_last (w_last)
  );
  always_ff @(posedge i_clk)
    r_state <= i_res ? S_GREEN : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_GREEN:   if (w_exit && (i_night || r_wait)) w_next = S_YELLOW;
      S_YELLOW:  if (w_exit) w_next = i_night ? S_BLINK : r_wait ? S_RED_CLR : S_RED_YEL;
      S_RED_CLR: if (w_exit) w_next = S_WALK;
      S_WALK:    if (w_exit) w_next = S_PED_CLR;
      S_PED_CLR: if (w_exit) w_next = S_RED_YEL;
      S_RED_YEL: if (w_exit) w_next = S_GREEN;
      S_BLINK:   if (i_tick && !i_night) w_next = S_PED_CLR;
      default:   w_next = S_GREEN;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_wait  <= 1'b0;
      r_blink <= 1'b1;
      r_req_q <= 1'b0;
    end else begin
      r_req_q <= i_req;
      r_blink <= (w_enter && w_next == S_BLINK) ? 1'b1 : (r_state == S_BLINK && i_tick) ? ~r_blink : r_blink;
      r_wait  <= w_clr ? 1'b0 : w_set ? 1'b1 : r_wait;
    end
  end
  always_comb begin
    o_car_g   = r_state == S_GREEN;
    o_car_y   = r_state == S_YELLOW || r_state == S_RED_YEL || (r_state == S_BLINK && r_blink);
    o_car_r   = r_state == S_RED_CLR || r_state == S_WALK || r_state == S_PED_CLR || r_state == S_RED_YEL;
    o_ped_g   = r_state == S_WALK;
    o_ped_r   = r_state != S_WALK && r_state != S_BLINK;
    o_disp_en = r_state == S_WALK;
    o_wait    = r_wait;
  end
endmodule

// File: tb/tb_ampel_ctrl.sv
// tb_ampel_ctrl: directed self-checking bench for the pedestrian-crossing sequencer
module tb_ampel_ctrl;
  logic       clk = 0, res = 0, tick = 0, req = 0, night = 0;
  logic       car_r, car_y, car_g, ped_r, ped_g, wt, disp_en;
  logic [3:0] cnt;
  int         n_chk = 0, n_pass = 0;
  localparam logic [4:0] L_GREEN = 5'b00110, L_YEL = 5'b01010, L_RED = 5'b10010,
                         L_WALK = 5'b10001, L_RY = 5'b11010, L_BY = 5'b01000, L_OFF = 5'b00000;
  ampel_ctrl dut (
    .i_clk(clk), .i_res(res), .i_tick(tick), .i_req(req), .i_night(night),
    .o_car_r(car_r), .o_car_y(car_y), .o_car_g(car_g), .o_ped_r(ped_r), .o_ped_g(ped_g),
    .o_wait(wt), .o_cnt(cnt), .o_disp_en(disp_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask
  task automatic st(input string tag, input logic [4:0] l, input int c, input logic w, input logic d);
    chk({tag, " lamps"}, int'({car_r, car_y, car_g, ped_r, ped_g}), int'(l));
    chk({tag, " cnt"}, int'(cnt), c);
    chk({tag, " wait"}, int'(wt), int'(w));
    chk({tag, " disp"}, int'(disp_en), int'(d));
  endtask
  task automatic step(input logic t, input logic r);
    tick = t;
    req  = r;
    @(posedge clk);
    #1;
    tick = 0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0);
  endtask
  initial begin
    #1;
    res = 1;
    step(1, 1);
    res = 0;
    req = 0;
    step(0, 0);
    st("reset", L_GREEN, 8, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 0);
      st($sformatf("green t%0d", i), L_GREEN, (8 - i > 1) ? 8 - i : 1, 0, 0);
    end
    step(0, 1);
    st("req edge", L_GREEN, 1, 1, 0);
    step(0, 0);
    step(1, 0);
    st("yellow entry", L_YEL, 3, 1, 0);
    ticks(2);
    st("yellow last", L_YEL, 1, 1, 0);
    step(1, 0);
    st("red_clr entry", L_RED, 2, 1, 0);
    ticks(2);
    st("walk entry", L_WALK, 6, 0, 1);
    step(0, 1);
    step(0, 0);
    st("walk press ignored", L_WALK, 6, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      step(1, 0);
      st($sformatf("walk t%0d", i), L_WALK, 6 - i, 0, 1);
    end
    step(1, 0);
    st("ped_clr entry", L_RED, 2, 0, 0);
    ticks(2);
    st("red_yel", L_RY, 1, 0, 0);
    step(1, 0);
    st("green again", L_GREEN, 8, 0, 0);
    ticks(2);
    step(0, 1);
    step(0, 0);
    st("early req", L_GREEN, 6, 1, 0);
    ticks(5);
    st("min green hold", L_GREEN, 1, 1, 0);
    step(1, 0);
    st("yellow after min green", L_YEL, 3, 1, 0);
    ticks(14);
    st("cycle 2 back to green", L_GREEN, 8, 0, 0);
    step(0, 1);
    step(0, 0);
    night = 1;
    ticks(7);
    st("night green hold", L_GREEN, 1, 1, 0);
    step(1, 0);
    st("night yellow", L_YEL, 3, 1, 0);
    ticks(3);
    st("blink entry", L_BY, 0, 0, 0);
    step(1, 0);
    st("blink off", L_OFF, 0, 0, 0);
    step(0, 1);
    step(0, 0);
    st("blink press ignored", L_OFF, 0, 0, 0);
    step(1, 0);
    st("blink on", L_BY, 0, 0, 0);
    night = 0;
    step(1, 0);
    st("blink exit ped_clr", L_RED, 2, 0, 0);
    ticks(2);
    st("blink exit red_yel", L_RY, 1, 0, 0);
    step(1, 0);
    st("blink exit green", L_GREEN, 8, 0, 0);
    step(0, 1);
    step(0, 0);
    ticks(8);
    st("pre-walk yellow", L_YEL, 3, 1, 0);
    ticks(5);
    st("pre-reset walk", L_WALK, 6, 0, 1);
    ticks(3);
    st("walk cnt3", L_WALK, 3, 0, 1);
    res = 1;
    night = 1;
    step(1, 0);
    res = 0;
    night = 0;
    st("reset in walk", L_GREEN, 8, 0, 0);
    ticks(7);
    step(1, 1);
    st("exit tick with edge", L_GREEN, 1, 1, 0);
    step(0, 0);
    step(1, 0);
    st("yellow after edge", L_YEL, 3, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
